// File: rtl/rocketcpu_param_smoother_pkg.sv
// Shared constants for the audio parameter smoother and the SoC param bus.
package rocketcpu_param_smoother_pkg;
    localparam int RKT_N_PARAMS    = 18;
    localparam int RKT_PARAM_WIDTH = 32;
    localparam int RKT_SHIFT       = 4;

    typedef logic [RKT_PARAM_WIDTH-1:0] param_t;
endpackage

// File: rtl/rocketcpu_param_smoother_if.sv
// Param bus between the CPU register block (master) and the smoother (slave).
interface rocketcpu_param_smoother_if
    import rocketcpu_param_smoother_pkg::*;
#(
    parameter int N_PARAMS = RKT_N_PARAMS,
    parameter int WIDTH    = RKT_PARAM_WIDTH
);
    logic [N_PARAMS*WIDTH-1:0] i_param;
    logic                      i_tick;
    logic                      i_snap;
    logic [N_PARAMS*WIDTH-1:0] o_param;
    logic                      o_busy;
    logic                      o_done;
    logic                      o_overrun;

    modport master (output i_param, i_tick, i_snap,
                    input  o_param, o_busy, o_done, o_overrun);
    modport slave  (input  i_param, i_tick, i_snap,
                    output o_param, o_busy, o_done, o_overrun);
endinterface

// File: rtl/rocketcpu_slew_step.sv
// One exponential smoothing step with a 1 LSB minimum move; never overshoots or wraps.
module rocketcpu_slew_step
    import rocketcpu_param_smoother_pkg::*;
#(
    parameter int WIDTH = RKT_PARAM_WIDTH,
    parameter int SHIFT = RKT_SHIFT
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    output logic [WIDTH-1:0] next
);
    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] s;
    logic signed [WIDTH:0] sum;
    logic                  sum_unused_msb;

    always_comb begin
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        s    = diff >>> SHIFT;
        sum  = $signed({1'b0, cur}) + s;
        next = cur;
        // s rounds toward -inf, so only a small positive diff yields s==0;
        // a small negative diff yields s==-1, which the general add covers.
        if (diff == '0)
            next = cur;
        else if (s == '0)
            next = cur + WIDTH'(1);
        else
            next = sum[WIDTH-1:0];
    end

    assign sum_unused_msb = sum[WIDTH];
endmodule

// File: rtl/rocketcpu_param_smoother.sv
// Tick-driven sweep that slews each audio parameter toward its CPU-written target.
module rocketcpu_param_smoother
    import rocketcpu_param_smoother_pkg::*;
#(
    parameter int                  N_PARAMS    = RKT_N_PARAMS,
    parameter int                  WIDTH       = RKT_PARAM_WIDTH,
    parameter int                  SHIFT       = RKT_SHIFT,
    parameter logic [N_PARAMS-1:0] BYPASS_MASK = '0
) (
    input  logic                              i_wb_clk,
    input  logic                              reset,
    rocketcpu_param_smoother_if.slave         bus
);
    localparam int CH_W = (N_PARAMS > 1) ? $clog2(N_PARAMS) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_PARAMS - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [0:0]                     state;
    logic [CH_W-1:0]                ch;
    logic                           pending;
    logic                           done_q;
    logic                           overrun_q;
    logic [N_PARAMS-1:0][WIDTH-1:0] cur_q;
    logic [N_PARAMS-1:0][WIDTH-1:0] tgt;
    logic [WIDTH-1:0]               step_next;

    assign tgt = bus.i_param;

    rocketcpu_slew_step #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_step (
        .cur  (cur_q[ch]),
        .tgt  (tgt[ch]),
        .next (step_next)
    );

    always_ff @(posedge i_wb_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ch        <= '0;
            pending   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            case (state)
                IDLE: begin
                    // snap takes priority and swallows a coincident tick
                    if (!bus.i_snap && bus.i_tick) begin
                        state <= SWEEP;
                        ch    <= '0;
                    end
                end
                SWEEP: begin
                    if (bus.i_snap) begin
                        state   <= IDLE;
                        ch      <= '0;
                        pending <= 1'b0;
                    end else begin
                        if (bus.i_tick)
                            overrun_q <= 1'b1;
                        if (ch == LAST_CH) begin
                            // a tick on the final edge chains straight into the next sweep
                            done_q  <= 1'b1;
                            ch      <= '0;
                            pending <= 1'b0;
                            state   <= (pending || bus.i_tick) ? SWEEP : IDLE;
                        end else begin
                            ch <= ch + CH_W'(1);
                            if (bus.i_tick)
                                pending <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_wb_clk or posedge reset) begin
        if (reset) begin
            cur_q <= '0;
        end else begin
            for (int k = 0; k < N_PARAMS; k++) begin
                if (BYPASS_MASK[k] || bus.i_snap)
                    cur_q[k] <= tgt[k];
                else if (state == SWEEP && ch == CH_W'(k))
                    cur_q[k] <= step_next;
            end
        end
    end

    assign bus.o_param   = cur_q;
    assign bus.o_busy    = (state == SWEEP);
    assign bus.o_done    = done_q;
    assign bus.o_overrun = overrun_q;
endmodule

// File: tb/tb_rocketcpu_param_smoother.sv
// Directed bench for the param smoother: ramp, min step, full scale, overrun, snap, bypass, reset.
module tb_rocketcpu_param_smoother;
    import rocketcpu_param_smoother_pkg::*;

    localparam int N = 18;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rocketcpu_param_smoother_if #(.N_PARAMS(N), .WIDTH(W)) bus ();

    rocketcpu_param_smoother #(
        .N_PARAMS(N), .WIDTH(W), .SHIFT(4), .BYPASS_MASK(18'h00004)
    ) dut (
        .i_wb_clk (clk),
        .reset    (rst),
        .bus      (bus)
    );

    logic [W-1:0] tgt [N];
    for (genvar g = 0; g < N; g++) begin : g_tgt
        assign bus.i_param[g*W +: W] = tgt[g];
    end

    int errors = 0;
    int checks = 0;

    function automatic logic [W-1:0] outp(int k);
        return bus.o_param[k*W +: W];
    endfunction

    task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // tick sampled at edge T; returns at the negedge after edge T+18
    task automatic tick_sweep();
        @(negedge clk) bus.i_tick = 1'b1;
        @(negedge clk) bus.i_tick = 1'b0;
        repeat (18) @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] prev0, prev17;
        logic         mono_ok;

        bus.i_tick = 1'b0;
        bus.i_snap = 1'b0;
        for (int k = 0; k < N; k++) tgt[k] = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ch0", outp(0), 32'h0);
        chk("rst_ch17", outp(17), 32'h0);
        chk("rst_busy", 32'(bus.o_busy), 32'h0);
        chk("rst_done", 32'(bus.o_done), 32'h0);
        chk("rst_ovr", 32'(bus.o_overrun), 32'h0);
        rst = 1'b0;

        tgt[0]  = 32'h0000_1000;
        tgt[2]  = 32'h0000_1234;
        tgt[3]  = 32'h0000_0005;
        tgt[17] = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("bypass_ch2", outp(2), 32'h1234);
        chk("notick_ch0", outp(0), 32'h0);

        // first sweep with latency checks
        bus.i_tick = 1'b1;
        @(negedge clk) bus.i_tick = 1'b0;
        chk("sweep_busy", 32'(bus.o_busy), 32'h1);
        @(negedge clk);
        chk("t1_ch0", outp(0), 32'h100);
        chk("t1_ch3_early", outp(3), 32'h0);
        repeat (16) @(negedge clk);
        chk("t17_ch17", outp(17), 32'h0);
        chk("t17_done", 32'(bus.o_done), 32'h0);
        @(negedge clk);
        chk("t18_ch17", outp(17), 32'h0FFF_FFFF);
        chk("t18_done", 32'(bus.o_done), 32'h1);
        chk("t18_busy", 32'(bus.o_busy), 32'h0);
        chk("t18_ch3", outp(3), 32'h1);

        tick_sweep();
        chk("tick2_ch0", outp(0), 32'h1F0);
        chk("tick2_ch3", outp(3), 32'h2);
        chk("tick2_ch17", outp(17), 32'h1EFF_FFFF);

        for (int i = 3; i <= 6; i++) begin
            tick_sweep();
            chk($sformatf("up_ch3_%0d", i), outp(3), (i < 5) ? W'(i) : 32'h5);
        end
        tgt[3] = 32'h0;
        for (int i = 1; i <= 6; i++) begin
            tick_sweep();
            chk($sformatf("dn_ch3_%0d", i), outp(3), (i < 5) ? W'(5 - i) : 32'h0);
        end

        // convergence without overshoot or wrap
        mono_ok = 1'b1;
        for (int i = 0; i < 400; i++) begin
            prev0  = outp(0);
            prev17 = outp(17);
            tick_sweep();
            if (outp(0) < prev0 || outp(0) > 32'h1000 || outp(17) < prev17) mono_ok = 1'b0;
        end
        chk("monotonic", 32'(mono_ok), 32'h1);
        chk("conv_ch17", outp(17), 32'hFFFF_FFFF);
        chk("conv_ch0", outp(0), 32'h1000);

        // overrun: ticks at T, T+5, T+9
        bus.i_tick = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("ovr_done_%0d", i), 32'(bus.o_done), 32'((i == 18) || (i == 36)));
            chk($sformatf("ovr_pulse_%0d", i), 32'(bus.o_overrun), 32'((i == 5) || (i == 9)));
            chk($sformatf("ovr_busy_%0d", i), 32'(bus.o_busy), 32'(i < 36));
            bus.i_tick = (i == 4) || (i == 8);
        end

        // snap while the sweep sits at ch=7
        for (int k = 0; k < N; k++) tgt[k] = 32'h100 * k + 32'h77;
        bus.i_tick = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.i_tick = 1'b0;
            bus.i_snap = (i == 7);
            if (i == 8) begin
                for (int k = 0; k < N; k++)
                    chk($sformatf("snap_ch%0d", k), outp(k), tgt[k]);
                chk("snap_busy", 32'(bus.o_busy), 32'h0);
            end
            chk($sformatf("snap_nodone_%0d", i), 32'(bus.o_done), 32'h0);
        end

        // snap and tick together: snap wins
        for (int k = 0; k < N; k++) tgt[k] = 32'hA000 + k;
        bus.i_snap = 1'b1;
        bus.i_tick = 1'b1;
        @(negedge clk);
        bus.i_snap = 1'b0;
        bus.i_tick = 1'b0;
        chk("snaptick_ch0", outp(0), 32'hA000);
        chk("snaptick_ch17", outp(17), 32'hA011);
        chk("snaptick_busy", 32'(bus.o_busy), 32'h0);
        chk("snaptick_ovr", 32'(bus.o_overrun), 32'h0);
        repeat (3) @(negedge clk);
        chk("snaptick_idle", 32'(bus.o_busy), 32'h0);

        // async reset mid-sweep
        tgt[0] = 32'h5000;
        tgt[9] = 32'h9000;
        bus.i_tick = 1'b1;
        @(negedge clk) bus.i_tick = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++)
            chk($sformatf("arst_ch%0d", k), outp(k), 32'h0);
        chk("arst_busy", 32'(bus.o_busy), 32'h0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("arst_nodone_%0d", i), 32'(bus.o_done), 32'h0);
        end
        chk("arst_ch0_hold", outp(0), 32'h0);
        chk("arst_bypass", outp(2), tgt[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
